score_keeper: RTL and testbench

- Sits directly downstream of the per-block hit/slice detector. Consumes its slice, miss and obstacle-hit events.
- Maintains game score, combo, Beat-Saber-style multiplier and player health.
- Runs the game-level state machine: idle, playing, won, lost.
- Outputs feed the HUD renderer and the game controller.

---
 rtl/score_keeper.sv | 175 +++++++++++++++++
 tb/tb_score_keeper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Purpose : game score/combo/multiplier/health tracker and IDLE/PLAYING/WON/LOST state machine.
// Latency : events sampled on one clk_in edge are visible on outputs (and acks pulse) right after that edge.
// Backpressure: none; events are consumed every cycle, duplicates are filtered by block ID.
//
// Ports:
//   clk_in, rst_n_in          clock, async active-low reset
//   start_in, song_done_in    game control (start pulse, song finished level)
//   block_sliced_in/sliced_ID_in   slice event + block ID
//   block_missed_in/missed_ID_in   miss level + current block ID
//   player_hit_in             obstacle hit, counts every high cycle
//   game_state_out            0=IDLE 1=PLAYING 2=WON 3=LOST
//   score_out, combo_out, multiplier_out, health_out   HUD values
//   slice_ack_out, miss_ack_out   one-cycle acceptance pulses
module score_keeper #(
    parameter int BASE_POINTS = 100,
    parameter int HEALTH_MAX  = 100,
    parameter int HEALTH_GAIN = 1,
    parameter int HEALTH_MISS = 10,
    parameter int HEALTH_HIT  = 15
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        song_done_in,
    input  logic        block_sliced_in,
    input  logic [7:0]  sliced_ID_in,
    input  logic        block_missed_in,
    input  logic [7:0]  missed_ID_in,
    input  logic        player_hit_in,
    output logic [1:0]  game_state_out,
    output logic [19:0] score_out,
    output logic [9:0]  combo_out,
    output logic [3:0]  multiplier_out,
    output logic [6:0]  health_out,
    output logic        slice_ack_out,
    output logic        miss_ack_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        WON     = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam logic [7:0]  ID_NONE   = 8'hFF;
    localparam logic [19:0] SCORE_SAT = 20'hFFFFF;
    localparam logic [9:0]  COMBO_SAT = 10'd1023;

    state_t      state;
    logic [2:0]  progress;
    logic [7:0]  last_slice_id;
    logic [7:0]  last_miss_id;

    logic        playing;
    logic        slice_acc;
    logic        miss_acc;
    logic        hit_acc;
    logic        penalty;
    logic        restart;
    logic [23:0] score_sum;
    logic [19:0] score_nxt;
    logic [9:0]  combo_nxt;
    logic [3:0]  mult_nxt;
    logic [2:0]  progress_nxt;
    logic [3:0]  progress_inc;
    logic [3:0]  threshold;
    logic signed [8:0] health_calc;
    logic [6:0]  health_nxt;

    always_comb begin
        playing   = (state == PLAYING);
        restart   = start_in && !playing;
        slice_acc = playing && block_sliced_in &&
                    (sliced_ID_in != last_slice_id) && (sliced_ID_in != ID_NONE);
        // A block already sliced must never also be counted as missed.
        miss_acc  = playing && block_missed_in &&
                    (missed_ID_in != last_miss_id) && (missed_ID_in != last_slice_id) &&
                    (missed_ID_in != ID_NONE);
        hit_acc   = playing && player_hit_in;
        penalty   = miss_acc || hit_acc;

        // Score always uses the multiplier in force before this cycle's events.
        score_sum = {4'd0, score_out} + 24'(BASE_POINTS) * {20'd0, multiplier_out};
        score_nxt = score_out;
        if (slice_acc)
            score_nxt = (score_sum > {4'd0, SCORE_SAT}) ? SCORE_SAT : score_sum[19:0];

        combo_nxt = combo_out;
        if (penalty)
            combo_nxt = 10'd0;
        else if (slice_acc && combo_out != COMBO_SAT)
            combo_nxt = combo_out + 10'd1;

        // Slices needed to double equals twice the current multiplier (1x:2, 2x:4, 4x:8).
        threshold    = {multiplier_out[2:0], 1'b0};
        progress_inc = {1'b0, progress} + 4'd1;
        mult_nxt     = multiplier_out;
        progress_nxt = progress;
        if (penalty) begin
            progress_nxt = 3'd0;
            mult_nxt     = (multiplier_out == 4'd1) ? 4'd1 : (multiplier_out >> 1);
        end else if (slice_acc) begin
            if (multiplier_out == 4'd8) begin
                progress_nxt = 3'd0;
            end else if (progress_inc == threshold) begin
                progress_nxt = 3'd0;
                mult_nxt     = {multiplier_out[2:0], 1'b0};
            end else begin
                progress_nxt = progress_inc[2:0];
            end
        end

        // Net health change in signed 9-bit space, then clamp to 0..HEALTH_MAX.
        health_calc = $signed({2'b00, health_out})
                    + (slice_acc ? $signed(9'(HEALTH_GAIN)) : 9'sd0)
                    - (miss_acc  ? $signed(9'(HEALTH_MISS)) : 9'sd0)
                    - (hit_acc   ? $signed(9'(HEALTH_HIT))  : 9'sd0);
        if (health_calc[8])
            health_nxt = 7'd0;
        else if (health_calc > $signed(9'(HEALTH_MAX)))
            health_nxt = 7'(HEALTH_MAX);
        else
            health_nxt = health_calc[6:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            score_out      <= 20'd0;
            combo_out      <= 10'd0;
            multiplier_out <= 4'd1;
            health_out     <= 7'(HEALTH_MAX);
            slice_ack_out  <= 1'b0;
            miss_ack_out   <= 1'b0;
            progress       <= 3'd0;
            last_slice_id  <= ID_NONE;
            last_miss_id   <= ID_NONE;
        end else if (restart) begin
            state          <= PLAYING;
            score_out      <= 20'd0;
            combo_out      <= 10'd0;
            multiplier_out <= 4'd1;
            health_out     <= 7'(HEALTH_MAX);
            slice_ack_out  <= 1'b0;
            miss_ack_out   <= 1'b0;
            progress       <= 3'd0;
            last_slice_id  <= ID_NONE;
            last_miss_id   <= ID_NONE;
        end else if (playing) begin
            score_out      <= score_nxt;
            combo_out      <= combo_nxt;
            multiplier_out <= mult_nxt;
            health_out     <= health_nxt;
            progress       <= progress_nxt;
            slice_ack_out  <= slice_acc;
            miss_ack_out   <= penalty;
            if (slice_acc)
                last_slice_id <= sliced_ID_in;
            if (miss_acc)
                last_miss_id <= missed_ID_in;
            // Death takes priority over finishing the song on the same edge.
            if (health_nxt == 7'd0)
                state <= LOST;
            else if (song_done_in)
                state <= WON;
        end else begin
            slice_ack_out <= 1'b0;
            miss_ack_out  <= 1'b0;
        end
    end

    assign game_state_out = state;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic        song_done_in;
    logic        block_sliced_in;
    logic [7:0]  sliced_ID_in;
    logic        block_missed_in;
    logic [7:0]  missed_ID_in;
    logic        player_hit_in;
    logic [1:0]  game_state_out;
    logic [19:0] score_out;
    logic [9:0]  combo_out;
    logic [3:0]  multiplier_out;
    logic [6:0]  health_out;
    logic        slice_ack_out;
    logic        miss_ack_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    score_keeper dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .song_done_in    (song_done_in),
        .block_sliced_in (block_sliced_in),
        .sliced_ID_in    (sliced_ID_in),
        .block_missed_in (block_missed_in),
        .missed_ID_in    (missed_ID_in),
        .player_hit_in   (player_hit_in),
        .game_state_out  (game_state_out),
        .score_out       (score_out),
        .combo_out       (combo_out),
        .multiplier_out  (multiplier_out),
        .health_out      (health_out),
        .slice_ack_out   (slice_ack_out),
        .miss_ack_out    (miss_ack_out)
    );

    always #5 clk_in = ~clk_in;

    // Drive one cycle of inputs at the falling edge, then sample 1ns after the rising edge.
    task automatic step(input logic sl, input logic [7:0] sid, input logic ms,
                        input logic [7:0] mid, input logic hit, input logic st,
                        input logic sd);
        @(negedge clk_in);
        block_sliced_in = sl;
        sliced_ID_in    = sid;
        block_missed_in = ms;
        missed_ID_in    = mid;
        player_hit_in   = hit;
        start_in        = st;
        song_done_in    = sd;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    endtask

    // Finish the current game as WON, then start a fresh one.
    task automatic new_game();
        step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        idle_step();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        start_in = 1'b0; song_done_in = 1'b0; block_sliced_in = 1'b0; sliced_ID_in = 8'hFF;
        block_missed_in = 1'b0; missed_ID_in = 8'hFF; player_hit_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        total_cnt++; if (game_state_out !== 2'd0) $display("FAIL rst_state: got %0d want 0", game_state_out); else pass_cnt++;
        total_cnt++; if (score_out !== 20'd0) $display("FAIL rst_score: got %0d want 0", score_out); else pass_cnt++;
        total_cnt++; if (combo_out !== 10'd0) $display("FAIL rst_combo: got %0d want 0", combo_out); else pass_cnt++;
        total_cnt++; if (multiplier_out !== 4'd1) $display("FAIL rst_mult: got %0d want 1", multiplier_out); else pass_cnt++;
        total_cnt++; if (health_out !== 7'd100) $display("FAIL rst_health: got %0d want 100", health_out); else pass_cnt++;
        total_cnt++; if ({slice_ack_out, miss_ack_out} !== 2'b00) $display("FAIL rst_acks: got %b want 00", {slice_ack_out, miss_ack_out}); else pass_cnt++;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        // Events in IDLE are ignored.
        step(1'b1, 8'd4, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (slice_ack_out !== 1'b0 || miss_ack_out !== 1'b0 || score_out !== 20'd0 || health_out !== 7'd100)
            $display("FAIL idle_ignore: got ack=%b%b score=%0d health=%0d want 00/0/100", slice_ack_out, miss_ack_out, score_out, health_out); else pass_cnt++;
    endtask

    task automatic test_slices();
        step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (game_state_out !== 2'd1) $display("FAIL start_state: got %0d want 1", game_state_out); else pass_cnt++;
        step(1'b1, 8'd1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (score_out !== 20'd100 || slice_ack_out !== 1'b1) $display("FAIL slice1: got score=%0d ack=%b want 100/1", score_out, slice_ack_out); else pass_cnt++;
        step(1'b1, 8'd2, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (score_out !== 20'd200) $display("FAIL slice2_score: got %0d want 200", score_out); else pass_cnt++;
        total_cnt++; if (multiplier_out !== 4'd2) $display("FAIL slice2_mult: got %0d want 2", multiplier_out); else pass_cnt++;
        step(1'b1, 8'd3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (score_out !== 20'd400) $display("FAIL slice3_score: got %0d want 400", score_out); else pass_cnt++;
        total_cnt++; if (combo_out !== 10'd3) $display("FAIL slice3_combo: got %0d want 3", combo_out); else pass_cnt++;
        total_cnt++; if (health_out !== 7'd100) $display("FAIL slice3_health: got %0d want 100", health_out); else pass_cnt++;
        idle_step();
        total_cnt++; if (slice_ack_out !== 1'b0) $display("FAIL slice_ack_drop: got %b want 0", slice_ack_out); else pass_cnt++;
    endtask

    task automatic test_held_slice();
        int acks = 0;
        new_game();
        total_cnt++; if (game_state_out !== 2'd1 || score_out !== 20'd0) $display("FAIL restart: got state=%0d score=%0d want 1/0", game_state_out, score_out); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'd5, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
            if (slice_ack_out) acks++;
        end
        idle_step();
        total_cnt++; if (acks !== 1) $display("FAIL held_slice_acks: got %0d want 1", acks); else pass_cnt++;
        total_cnt++; if (score_out !== 20'd100) $display("FAIL held_slice_score: got %0d want 100", score_out); else pass_cnt++;
    endtask

    task automatic test_held_miss();
        int acks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'hFF, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
            if (miss_ack_out) acks++;
        end
        idle_step();
        total_cnt++; if (acks !== 1) $display("FAIL held_miss_acks: got %0d want 1", acks); else pass_cnt++;
        total_cnt++; if (health_out !== 7'd90) $display("FAIL held_miss_health: got %0d want 90", health_out); else pass_cnt++;
        total_cnt++; if (combo_out !== 10'd0) $display("FAIL held_miss_combo: got %0d want 0", combo_out); else pass_cnt++;
        new_game();
        step(1'b1, 8'd7, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'hFF, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
            if (miss_ack_out) acks++;
        end
        idle_step();
        total_cnt++; if (acks !== 0) $display("FAIL sliced_miss_acks: got %0d want 0", acks); else pass_cnt++;
        total_cnt++; if (health_out !== 7'd100 || combo_out !== 10'd1) $display("FAIL sliced_miss_state: got health=%0d combo=%0d want 100/1", health_out, combo_out); else pass_cnt++;
    endtask

    task automatic test_multiplier();
        logic [3:0] m2, m6;
        new_game();
        m2 = 4'd0; m6 = 4'd0;
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 8'(9 + i), 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
            if (i == 2) m2 = multiplier_out;
            if (i == 6) m6 = multiplier_out;
        end
        total_cnt++; if (m2 !== 4'd2) $display("FAIL mult_after2: got %0d want 2", m2); else pass_cnt++;
        total_cnt++; if (m6 !== 4'd4) $display("FAIL mult_after6: got %0d want 4", m6); else pass_cnt++;
        total_cnt++; if (multiplier_out !== 4'd8) $display("FAIL mult_after14: got %0d want 8", multiplier_out); else pass_cnt++;
        total_cnt++; if (score_out !== 20'd4200) $display("FAIL mult_score: got %0d want 4200", score_out); else pass_cnt++;
        total_cnt++; if (combo_out !== 10'd14) $display("FAIL mult_combo: got %0d want 14", combo_out); else pass_cnt++;
        step(1'b0, 8'hFF, 1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (multiplier_out !== 4'd4 || combo_out !== 10'd0 || miss_ack_out !== 1'b1)
            $display("FAIL mult_miss: got mult=%0d combo=%0d ack=%b want 4/0/1", multiplier_out, combo_out, miss_ack_out); else pass_cnt++;
        total_cnt++; if (score_out !== 20'd4200 || health_out !== 7'd90) $display("FAIL mult_miss_sh: got score=%0d health=%0d want 4200/90", score_out, health_out); else pass_cnt++;
        idle_step();
    endtask

    task automatic test_hits_lost();
        new_game();
        for (int i = 0; i < 6; i++)
            step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (health_out !== 7'd10 || game_state_out !== 2'd1) $display("FAIL hits6: got health=%0d state=%0d want 10/1", health_out, game_state_out); else pass_cnt++;
        // Seventh hit coincides with song end: losing wins.
        step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
        total_cnt++; if (health_out !== 7'd0) $display("FAIL hits7_health: got %0d want 0", health_out); else pass_cnt++;
        total_cnt++; if (game_state_out !== 2'd3) $display("FAIL hits7_state: got %0d want 3", game_state_out); else pass_cnt++;
        step(1'b1, 8'd40, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (slice_ack_out !== 1'b0 || score_out !== 20'd0 || game_state_out !== 2'd3)
            $display("FAIL lost_ignore: got ack=%b score=%0d state=%0d want 0/0/3", slice_ack_out, score_out, game_state_out); else pass_cnt++;
        step(1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (game_state_out !== 2'd1 || score_out !== 20'd0 || health_out !== 7'd100)
            $display("FAIL lost_restart: got state=%0d score=%0d health=%0d want 1/0/100", game_state_out, score_out, health_out); else pass_cnt++;
        idle_step();
    endtask

    task automatic test_simultaneous();
        step(1'b1, 8'd1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd2, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (multiplier_out !== 4'd2 || score_out !== 20'd200) $display("FAIL simul_pre: got mult=%0d score=%0d want 2/200", multiplier_out, score_out); else pass_cnt++;
        step(1'b1, 8'd9, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        total_cnt++; if (score_out !== 20'd400) $display("FAIL simul_score: got %0d want 400", score_out); else pass_cnt++;
        total_cnt++; if (combo_out !== 10'd0 || multiplier_out !== 4'd1) $display("FAIL simul_cm: got combo=%0d mult=%0d want 0/1", combo_out, multiplier_out); else pass_cnt++;
        total_cnt++; if (health_out !== 7'd86) $display("FAIL simul_health: got %0d want 86", health_out); else pass_cnt++;
        total_cnt++; if ({slice_ack_out, miss_ack_out} !== 2'b11) $display("FAIL simul_acks: got %b want 11", {slice_ack_out, miss_ack_out}); else pass_cnt++;
        idle_step();
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'd20, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        // Still well before the next rising edge.
        total_cnt++; if (game_state_out !== 2'd0 || score_out !== 20'd0 || combo_out !== 10'd0)
            $display("FAIL async_rst_a: got state=%0d score=%0d combo=%0d want 0/0/0", game_state_out, score_out, combo_out); else pass_cnt++;
        total_cnt++; if (multiplier_out !== 4'd1 || health_out !== 7'd100 || slice_ack_out !== 1'b0)
            $display("FAIL async_rst_b: got mult=%0d health=%0d ack=%b want 1/100/0", multiplier_out, health_out, slice_ack_out); else pass_cnt++;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle_step();
        total_cnt++; if (game_state_out !== 2'd0) $display("FAIL post_rst_state: got %0d want 0", game_state_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_slices();
        test_held_slice();
        test_held_miss();
        test_multiplier();
        test_hits_lost();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
